icache_mem_responder: RTL and testbench

- Memory-side responder for the instruction cache line-fill request/ack protocol.
- Accepts one line-read request from the icache controller and issues BEATS word reads on the word-wide instruction memory bus.
- Assembles the returned words into one cache line and returns the line with a single-cycle ack.
- Supports abort of an in-flight fill on kill or request withdrawal.

---
 rtl/icache_mem_responder.sv | 136 +++++++++++++
 tb/tb_icache_mem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_mem_responder.sv
// icache_mem_responder
// Memory-side line-fill engine for the instruction cache. Takes one line
// request, walks the word-wide instruction memory bus for every word of the
// line, assembles the words and hands the full line back with a one-cycle
// ack. A fill can be abandoned by kill or by the cache dropping its request;
// an outstanding memory read is always allowed to finish before returning
// to idle, because the memory bus has no cancel.
module icache_mem_responder #(
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32,
   parameter int LINE_W = 128
) (
   input  logic              clk_i,
   input  logic              rst_i,
   // cache side
   input  logic              icache2mem_req_i,
   input  logic [ADDR_W-1:0] icache2mem_addr_i,
   input  logic              icache2mem_kill_i,
   output logic              mem2icache_ack_o,
   output logic [LINE_W-1:0] mem2icache_data_o,
   // instruction memory side
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [WORD_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i
);

   // LINE_W must be a multiple of WORD_W and hold at least two words.
   localparam int BEATS      = LINE_W / WORD_W;
   localparam int BEAT_W     = $clog2(BEATS);
   localparam int OFF_W      = $clog2(LINE_W / 8);
   localparam int WORD_BYTES = WORD_W / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      RESP  = 2'd2,
      ABORT = 2'd3
   } state_t;

   state_t            state_q;
   logic [BEAT_W-1:0] beat_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] line_q;
   logic [LINE_W-1:0] data_q;
   logic              req_q;
   logic              ack_q;

   // line buffer with the current memory word merged into the current beat slot
   logic [LINE_W-1:0] line_d;
   // line-aligned fill base derived from the cache address
   logic [ADDR_W-1:0] base_d;
   logic              last_beat_d;
   logic              abort_d;

   // offset bits inside the line select nothing; the fill always starts at word 0
   logic              addr_offset_unused;
   assign addr_offset_unused = ^icache2mem_addr_i[OFF_W-1:0];

   assign base_d      = {icache2mem_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign last_beat_d = (beat_q == BEAT_W'(BEATS - 1));
   assign abort_d     = icache2mem_kill_i || !icache2mem_req_i;

   // Word slot gi takes the memory data when it is the beat in flight, so beat 0
   // lands in the least-significant word of the line.
   for (genvar gi = 0; gi < BEATS; gi++) begin : g_merge
      assign line_d[gi*WORD_W +: WORD_W] = (beat_q == BEAT_W'(gi)) ? mem_rdata_i
                                                                   : line_q[gi*WORD_W +: WORD_W];
   end

   // Fill sequencer: every output is a register; only the ack is gated by kill.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         beat_q  <= '0;
         addr_q  <= '0;
         line_q  <= '0;
         data_q  <= '0;
         req_q   <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (icache2mem_req_i && !icache2mem_kill_i) begin
                  addr_q  <= base_d;
                  beat_q  <= '0;
                  req_q   <= 1'b1;
                  state_q <= FETCH;
               end
            end
            FETCH: begin
               if (abort_d) begin
                  // a word returning in the abort cycle is simply dropped
                  if (mem_ack_i) begin
                     req_q   <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     state_q <= ABORT;
                  end
               end else if (mem_ack_i) begin
                  line_q <= line_d;
                  if (last_beat_d) begin
                     data_q  <= line_d;
                     req_q   <= 1'b0;
                     ack_q   <= 1'b1;
                     state_q <= RESP;
                  end else begin
                     beat_q <= beat_q + 1'b1;
                     addr_q <= addr_q + ADDR_W'(WORD_BYTES);
                  end
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            ABORT: begin
               // keep the read asserted until memory completes it, then discard
               if (mem_ack_i) begin
                  req_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem2icache_ack_o  = ack_q && !icache2mem_kill_i;
   assign mem2icache_data_o = data_q;
   assign mem_req_o         = req_q;
   assign mem_addr_o        = addr_q;

endmodule

// File: tb/tb_icache_mem_responder.sv
// Directed bench for icache_mem_responder: basic fill, wait states, kill in
// FETCH with and without a coincident memory ack, kill in RESP, reset mid-fill.
module tb_icache_mem_responder;

   localparam int ADDR_W = 32;
   localparam int WORD_W = 32;
   localparam int LINE_W = 128;

   logic              clk = 1'b0;
   logic              rst;
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              kill;
   logic              ack_o;
   logic [LINE_W-1:0] data_o;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] rdata;
   logic              mem_ack;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [LINE_W-1:0] line_a;
   logic [LINE_W-1:0] line_b;
   logic [LINE_W-1:0] line_d;
   logic [LINE_W-1:0] line_e;
   logic [LINE_W-1:0] line_g;

   always #5 clk = ~clk;

   icache_mem_responder #(
      .ADDR_W(ADDR_W),
      .WORD_W(WORD_W),
      .LINE_W(LINE_W)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .icache2mem_req_i  (req),
      .icache2mem_addr_i (addr),
      .icache2mem_kill_i (kill),
      .mem2icache_ack_o  (ack_o),
      .mem2icache_data_o (data_o),
      .mem_req_o         (mem_req),
      .mem_addr_o        (mem_addr),
      .mem_rdata_i       (rdata),
      .mem_ack_i         (mem_ack)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic chk128(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // Called in the first FETCH cycle; memory acks every cycle.
   task automatic zero_wait_fill(input string tag, input logic [31:0] base, input logic [LINE_W-1:0] line);
      for (int b = 0; b < 4; b++) begin
         chk1({tag, "_req"}, mem_req, 1'b1);
         chk32({tag, "_addr"}, mem_addr, base + 32'(4 * b));
         chk1({tag, "_noack"}, ack_o, 1'b0);
         mem_ack = 1'b1;
         rdata   = line[b*32 +: 32];
         tick();
      end
      mem_ack = 1'b0;
      chk1({tag, "_ack"}, ack_o, 1'b1);
      chk128({tag, "_line"}, data_o, line);
      chk1({tag, "_req_resp"}, mem_req, 1'b0);
      $display("fill %s base=%08h line=%032h", tag, base, data_o);
   endtask

   initial begin
      line_a = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
      line_b = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
      line_d = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
      line_e = {32'hE3E3E3E3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'hE0E0E0E0};
      line_g = {32'h0000F003, 32'h0000F002, 32'h0000F001, 32'h0000F000};

      rst = 1'b1; req = 1'b0; addr = '0; kill = 1'b0; mem_ack = 1'b0; rdata = '0;
      tick();
      tick();
      rst = 1'b0;
      chk1("rst_req", mem_req, 1'b0);
      chk1("rst_ack", ack_o, 1'b0);
      chk32("rst_addr", mem_addr, 32'h0);
      chk128("rst_data", data_o, '0);
      tick();
      chk1("idle_req", mem_req, 1'b0);
      $display("reset done");

      // basic fill, zero-wait memory; ack in cycle 5
      req = 1'b1; addr = 32'h8000_0014; cyc = 0;
      tick();
      zero_wait_fill("basic", 32'h8000_0010,
                     {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
      chk32("basic_latency", 32'(cyc), 32'd5);
      req = 1'b0;
      tick();
      chk1("basic_ack_pulse", ack_o, 1'b0);
      chk128("basic_hold", data_o, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});

      // wait states: three idle cycles before each memory ack; ack in cycle 17
      req = 1'b1; addr = 32'h0000_1004; cyc = 0;
      tick();
      for (int b = 0; b < 4; b++) begin
         for (int w = 0; w < 3; w++) begin
            chk1("wait_req", mem_req, 1'b1);
            chk32("wait_addr", mem_addr, 32'h0000_1000 + 32'(4 * b));
            chk1("wait_noack", ack_o, 1'b0);
            tick();
         end
         mem_ack = 1'b1;
         rdata   = line_a[b*32 +: 32];
         chk32("wait_addr_ack", mem_addr, 32'h0000_1000 + 32'(4 * b));
         tick();
         mem_ack = 1'b0;
      end
      chk32("wait_latency", 32'(cyc), 32'd17);
      chk1("wait_ack", ack_o, 1'b1);
      chk128("wait_line", data_o, line_a);
      req = 1'b0;
      tick();
      $display("fill wait-states line=%032h", data_o);

      // kill after beat 1, memory acks beat 2 two cycles later
      req = 1'b1; addr = 32'h0000_2000;
      tick();
      mem_ack = 1'b1; rdata = line_b[31:0];
      tick();
      rdata = line_b[63:32];
      tick();
      mem_ack = 1'b0; kill = 1'b1;
      tick();
      chk1("kill_abort_req", mem_req, 1'b1);
      chk1("kill_abort_ack", ack_o, 1'b0);
      kill = 1'b0; req = 1'b0;
      tick();
      chk1("kill_abort_hold", mem_req, 1'b1);
      mem_ack = 1'b1; rdata = line_b[95:64];
      chk1("kill_abort_ack2", ack_o, 1'b0);
      tick();
      mem_ack = 1'b0;
      chk1("kill_idle_req", mem_req, 1'b0);
      chk1("kill_idle_ack", ack_o, 1'b0);
      chk128("kill_keep_line", data_o, line_a);
      tick();
      chk1("kill_stay_idle", mem_req, 1'b0);
      $display("kill mid-fill done line=%032h", data_o);

      // kill coincident with a memory ack: straight to IDLE, then a fresh fill
      req = 1'b1; addr = 32'h0000_3000;
      tick();
      mem_ack = 1'b1; rdata = 32'hC0C0C0C0;
      tick();
      kill = 1'b1; rdata = 32'hC1C1C1C1;
      tick();
      kill = 1'b0; mem_ack = 1'b0;
      chk1("kill_ack_idle_req", mem_req, 1'b0);
      chk1("kill_ack_noack", ack_o, 1'b0);
      chk128("kill_ack_keep", data_o, line_a);
      tick();
      zero_wait_fill("refill", 32'h0000_3000, line_d);
      req = 1'b0;
      tick();

      // kill in the RESP cycle suppresses the ack
      req = 1'b1; addr = 32'h0000_5008;
      tick();
      zero_wait_fill("resp_kill", 32'h0000_5000, line_e);
      kill = 1'b1; req = 1'b0;
      #1;
      chk1("resp_kill_gated", ack_o, 1'b0);
      tick();
      kill = 1'b0;
      chk1("resp_kill_idle_req", mem_req, 1'b0);
      chk1("resp_kill_idle_ack", ack_o, 1'b0);
      tick();
      chk1("resp_kill_stay_idle", mem_req, 1'b0);
      $display("kill in resp done");

      // reset during beat 2, then a normal fill at 0x40
      req = 1'b1; addr = 32'h0000_4000;
      tick();
      mem_ack = 1'b1; rdata = 32'h12345678;
      tick();
      rdata = 32'h9ABCDEF0;
      tick();
      mem_ack = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      chk1("rstmid_req", mem_req, 1'b0);
      chk1("rstmid_ack", ack_o, 1'b0);
      chk128("rstmid_data", data_o, '0);
      chk32("rstmid_addr", mem_addr, 32'h0);
      addr = 32'h0000_0040;
      tick();
      zero_wait_fill("after_rst", 32'h0000_0040, line_g);
      req = 1'b0;
      tick();
      chk1("after_rst_pulse", ack_o, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
